// File: rtl/trans_meslen_if.sv
// Bundle between macfsm/transmit buffer and the transmit message length unit.
// master: macfsm side, drives load/tdlc/trtr/activ/abort and observes status.
// slave : trans_meslen, consumes the strobes and returns DLC bit / length / done flags.
// Optional byte counter signals exist only when TRANS_MESLEN_BYTECNT_EN is defined.
interface trans_meslen_if;
  logic       load;
  logic [3:0] tdlc;
  logic       trtr;
  logic       activ;
  logic       abort;
  logic       dlcbit;
  logic       dlcdone;
  logic       datadone;
  logic [3:0] tmlb;
  logic       busy;
`ifdef TRANS_MESLEN_BYTECNT_EN
  logic [3:0] bytecnt;
  logic       bytedone;
`endif

  modport master (
    output load, tdlc, trtr, activ, abort,
`ifdef TRANS_MESLEN_BYTECNT_EN
    input  bytecnt, bytedone,
`endif
    input  dlcbit, dlcdone, datadone, tmlb, busy
  );

  modport slave (
    input  load, tdlc, trtr, activ, abort,
`ifdef TRANS_MESLEN_BYTECNT_EN
    output bytecnt, bytedone,
`endif
    output dlcbit, dlcdone, datadone, tmlb, busy
  );
endinterface

// File: rtl/trans_meslen.sv
// Transmit-side message length unit of the CAN MAC.
// On a load event it captures DLC and RTR flag, serialises the 4 DLC bits MSB first on
// successive activ events, then counts data-field bits until the data field is complete.
// Ports:
//   clk_i   system clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     trans_meslen_if.slave: load/tdlc/trtr/activ/abort in;
//           dlcbit/dlcdone/datadone/tmlb/busy out
// Optional feature macro: TRANS_MESLEN_BYTECNT_EN adds bus.bytecnt (data bytes fully stepped)
// and bus.bytedone (one-clock pulse after every ByteBits data bits).
module trans_meslen #(
  parameter int unsigned MaxBytes = 8,
  parameter int unsigned ByteBits = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  trans_meslen_if.slave  bus
);

  localparam logic [3:0] MaxBytesW = 4'(MaxBytes);

  typedef enum logic [1:0] {StIdle, StDlc, StData, StDone} state_e;

  state_e     state_q;
  logic       load_prev_q;
  logic       activ_prev_q;
  logic [2:0] dlc_q;     // DLC bits not yet presented on dlcbit
  logic [2:0] shcnt_q;   // DLC bits still to be stepped
  logic [6:0] bitcnt_q;  // data bits still to be stepped
  logic       dlcbit_q;
  logic       dlcdone_q;
  logic       datadone_q;
  logic       busy_q;
  logic [3:0] tmlb_q;

`ifdef TRANS_MESLEN_BYTECNT_EN
  localparam int unsigned BitW = (ByteBits > 1) ? $clog2(ByteBits) : 1;
  logic [BitW-1:0] bitinbyte_q;
  logic [3:0]      bytecnt_q;
  logic            bytedone_q;
`endif

  logic       load_ev;
  logic       activ_ev;
  logic [3:0] tmlb_cap;

  always_comb begin
    load_ev  = bus.load & ~load_prev_q;
    activ_ev = bus.activ & ~activ_prev_q;
    // Remote frames carry no data; DLC values above MaxBytes clip to MaxBytes.
    if (bus.trtr) begin
      tmlb_cap = 4'd0;
    end else if (bus.tdlc > MaxBytesW) begin
      tmlb_cap = MaxBytesW;
    end else begin
      tmlb_cap = bus.tdlc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      load_prev_q  <= 1'b0;
      activ_prev_q <= 1'b0;
      dlc_q        <= 3'd0;
      shcnt_q      <= 3'd0;
      bitcnt_q     <= 7'd0;
      dlcbit_q     <= 1'b0;
      dlcdone_q    <= 1'b0;
      datadone_q   <= 1'b0;
      busy_q       <= 1'b0;
      tmlb_q       <= 4'd0;
`ifdef TRANS_MESLEN_BYTECNT_EN
      bitinbyte_q  <= '0;
      bytecnt_q    <= 4'd0;
      bytedone_q   <= 1'b0;
`endif
    end else begin
      // Edge memories track the inputs even through abort.
      load_prev_q  <= bus.load;
      activ_prev_q <= bus.activ;
`ifdef TRANS_MESLEN_BYTECNT_EN
      bytedone_q   <= 1'b0;
`endif
      if (bus.abort) begin
        state_q    <= StIdle;
        dlc_q      <= 3'd0;
        shcnt_q    <= 3'd0;
        bitcnt_q   <= 7'd0;
        dlcbit_q   <= 1'b0;
        dlcdone_q  <= 1'b0;
        datadone_q <= 1'b0;
        busy_q     <= 1'b0;
        tmlb_q     <= 4'd0;
`ifdef TRANS_MESLEN_BYTECNT_EN
        bitinbyte_q <= '0;
        bytecnt_q   <= 4'd0;
`endif
      end else if (load_ev) begin
        // Load wins over a coincident activ event: capture only, no shift.
        state_q    <= StDlc;
        dlcbit_q   <= bus.tdlc[3];
        dlc_q      <= bus.tdlc[2:0];
        shcnt_q    <= 3'd4;
        bitcnt_q   <= 7'd0;
        tmlb_q     <= tmlb_cap;
        dlcdone_q  <= 1'b0;
        datadone_q <= 1'b0;
        busy_q     <= 1'b1;
`ifdef TRANS_MESLEN_BYTECNT_EN
        bitinbyte_q <= '0;
        bytecnt_q   <= 4'd0;
`endif
      end else if (activ_ev) begin
        case (state_q)
          StDlc: begin
            dlc_q   <= {dlc_q[1:0], 1'b0};
            shcnt_q <= shcnt_q - 3'd1;
            if (shcnt_q == 3'd1) begin
              dlcdone_q <= 1'b1;
              dlcbit_q  <= 1'b0;
              if (tmlb_q == 4'd0) begin
                state_q    <= StDone;
                datadone_q <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                state_q  <= StData;
                bitcnt_q <= 7'(tmlb_q * ByteBits);
              end
            end else begin
              dlcbit_q <= dlc_q[2];
            end
          end
          StData: begin
            if (bitcnt_q != 7'd0) begin
              bitcnt_q <= bitcnt_q - 7'd1;
              if (bitcnt_q == 7'd1) begin
                state_q    <= StDone;
                datadone_q <= 1'b1;
                busy_q     <= 1'b0;
              end
`ifdef TRANS_MESLEN_BYTECNT_EN
              if (bitinbyte_q == BitW'(ByteBits - 1)) begin
                bitinbyte_q <= '0;
                bytecnt_q   <= bytecnt_q + 4'd1;
                bytedone_q  <= 1'b1;
              end else begin
                bitinbyte_q <= bitinbyte_q + 1'b1;
              end
`endif
            end
          end
          default: ;  // IDLE ignores activ; DONE holds everything
        endcase
      end
    end
  end

  assign bus.dlcbit   = dlcbit_q;
  assign bus.dlcdone  = dlcdone_q;
  assign bus.datadone = datadone_q;
  assign bus.tmlb     = tmlb_q;
  assign bus.busy     = busy_q;
`ifdef TRANS_MESLEN_BYTECNT_EN
  assign bus.bytecnt  = bytecnt_q;
  assign bus.bytedone = bytedone_q;
`endif

endmodule
